ireg_queue: RTL and testbench
=============================

# ireg_queue

Parametrised instruction register with elastic buffering between fetch and decode. It holds up to DEPTH fetched instructions with their PCs in arrival order. It presents the head entry with its MIPS fields already split out (opcode, funct, rs, rt, rd, shamt, 16-bit and 26-bit immediates, plus sign- and zero-extended immediates). Fetch and decode run decoupled by valid/ready handshakes, and a flush port discards all buffered work on branch/jump redirect.

## Interface
- DEPTH, 4, number of buffered entries; power of two, ≥ 2
- PC_W, 32, width of the stored PC
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer can accept (not full)
- in_ins  in  32  instruction word
- in_pc  in  PC_W  PC of in_ins
- flush  in  1  discard all entries this cycle
- out_valid  out  1  head entry present
- out_ready  in  1  decode consumes head this cycle
- out_ins  out  32  head instruction word
- out_pc  out  PC_W  head PC
- opcode  out  6  out_ins[31:26]
- rs  out  5  out_ins[25:21]
- rt  out  5  out_ins[20:16]
- rd  out  5  out_ins[15:11]
- shamt  out  5  out_ins[10:6]
- funct  out  6  out_ins[5:0]
- im1  out  16  out_ins[15:0]
- im2  out  26  out_ins[25:0]
- imm_sext  out  32  im1 sign-extended
- imm_zext  out  32  im1 zero-extended
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH {ins, pc} entries; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH; separate occupancy counter count.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH), combinational from state only, never from in_valid/out_ready. No bypass: a full buffer does not accept even when the head pops the same cycle.
- out_valid = (count != 0).
- push: mem[wp] ← {in_ins, in_pc}; wp ← wp+1.
- pop: rp ← rp+1.
- count ← count + push − pop. Push and pop in the same cycle leave count unchanged.
- flush (priority over push and pop): wp ← 0, rp ← 0, count ← 0. A word offered in the flush cycle is dropped, and fetch must re-present it if it is wanted.
- Head outputs: out_ins/out_pc = mem[rp] when out_valid; forced to all-zero when out_valid = 0. All field outputs are combinational slices/extensions of out_ins, so they are zero when empty.
- imm_sext = {{16{im1[15]}}, im1}; imm_zext = {16'b0, im1}.
- Handshake rule (checked by assertion): while in_valid=1 and in_ready=0, upstream holds in_ins/in_pc stable.
- Storage array contents are not reset. Only pointers and count are reset.

## Timing
- Reset: on a rising edge with rst=1, wp=rp=0 and count=0. Afterwards out_valid=0, in_ready=1, out_ins=out_pc=0, and all fields 0. rst overrides flush/push/pop.
- Reset mid-operation behaves identically to flush plus ignoring inputs that cycle.
- Latency: a word pushed at edge N is at the head (if the buffer was empty) with out_valid=1 after edge N, i.e. visible in cycle N+1. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0; pop frees a slot visible the next cycle.
- Empty (count=0): out_ready ignored, pointers unchanged.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across wrap.
- Flush takes effect at the edge: out_valid=0 and in_ready=1 in the following cycle.

## Test plan
- Decode R-type: reset, push 0x012A4020 at pc 0x00400000 → next cycle out_valid=1, opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, out_pc=0x00400000, count=1.
- Decode I/J-type: push 0x8D28FFFC then 0x08000010, pop both → first head opcode=0x23, rs=9, rt=8, im1=0xFFFC, imm_sext=0xFFFFFFFC, imm_zext=0x0000FFFC; second head opcode=0x02, im2=0x0000010.
- Fill/full (DEPTH=4): push 4 words with out_ready=0 → count=4, in_ready=0. A 5th offered word is not accepted. Pop one → in_ready=1 next cycle; order of popped words matches push order.
- Simultaneous push/pop with count=2, sustained for 10 cycles across pointer wrap → count stays 2, outputs in exact FIFO order, no loss or duplication.
- Flush with count=3 while in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_ins=0, in_ready=1, and the offered word is absent afterwards.
- rst asserted mid-stream with count=2 and push+pop active → next cycle count=0, out_valid=0, all field outputs 0, in_ready=1. Subsequent push of 0x012A4020 appears normally one cycle later.

Source files
------------

// File: rtl/ireg_queue.sv
// Elastic instruction register between fetch and decode: a DEPTH-entry FIFO of {ins, pc}
// that presents the head instruction with its MIPS fields split out.
module ireg_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ins,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_ins,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                im1,
  output logic [25:0]                im2,
  output logic [31:0]                imm_sext,
  output logic [31:0]                imm_zext,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]     mem_ins [DEPTH];
  logic [PC_W-1:0] mem_pc  [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // Ready depends on occupancy only; a full buffer never accepts, even on a same-cycle pop.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left unreset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_ins[wp_q] <= in_ins;
      mem_pc[wp_q]  <= in_pc;
    end
  end

  always_comb begin
    out_ins = '0;
    out_pc  = '0;
    if (out_valid) begin
      out_ins = mem_ins[rp_q];
      out_pc  = mem_pc[rp_q];
    end
  end

  assign opcode   = out_ins[31:26];
  assign rs       = out_ins[25:21];
  assign rt       = out_ins[20:16];
  assign rd       = out_ins[15:11];
  assign shamt    = out_ins[10:6];
  assign funct    = out_ins[5:0];
  assign im1      = out_ins[15:0];
  assign im2      = out_ins[25:0];
  assign imm_sext = {{16{im1[15]}}, im1};
  assign imm_zext = {16'b0, im1};

  // A stalled offer must stay put until taken (a redirect may replace it).
  property p_hold_stalled;
    @(posedge clk) disable iff (rst)
      (in_valid && !in_ready && !flush) |=> (!in_valid || flush || ($stable(in_ins) && $stable(in_pc)));
  endproperty
  a_hold_stalled: assert property (p_hold_stalled);

endmodule

// File: tb/tb_ireg_queue.sv
// Directed bench for ireg_queue; a negedge monitor checks the head against a queue of
// expected {ins, pc} entries filled by the stimulus process.
module tb_ireg_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_ins, out_ins, in_pc, out_pc, imm_sext, imm_zext;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] im1;
  logic [25:0] im2;
  logic [2:0]  count;

  ireg_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .im1       (im1),
    .im2       (im2),
    .imm_sext  (imm_sext),
    .imm_zext  (imm_zext),
    .count     (count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;
  logic        exp_acc = 1'b0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; acc states whether this offer is expected to be taken.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic r, input logic acc);
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    exp_acc   = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_ins"}, out_ins, 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_fields"}, {opcode, rs, rt, rd, shamt, funct}, 32'd0);
    chk({tag, "_imms"}, imm_sext | imm_zext | 32'(im2), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_count", 32'(count), 32'(exp_q.size()));
      chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("mon_in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        chk("mon_head_ins", out_ins, exp_q[0][63:32]);
        chk("mon_head_pc", out_pc, exp_q[0][31:0]);
      end else begin
        chk("mon_empty_ins", out_ins, 32'd0);
      end
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (exp_acc) exp_q.push_back({in_ins, in_pc});
      end
    end
  end

  initial begin
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    mon_en = 1'b1;
    idle(1'b0);
    chk_empty("reset");

    // R-type decode
    step(1'b1, 32'h012A4020, 32'h00400000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("r_out_valid", 32'(out_valid), 32'd1);
    chk("r_opcode", 32'(opcode), 32'd0);
    chk("r_rs", 32'(rs), 32'd9);
    chk("r_rt", 32'(rt), 32'd10);
    chk("r_rd", 32'(rd), 32'd8);
    chk("r_shamt", 32'(shamt), 32'd0);
    chk("r_funct", 32'(funct), 32'h20);
    chk("r_out_pc", out_pc, 32'h00400000);
    chk("r_count", 32'(count), 32'd1);
    idle(1'b1);

    // I-type then J-type
    step(1'b1, 32'h8D28FFFC, 32'h00400004, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h08000010, 32'h00400008, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("i_opcode", 32'(opcode), 32'h23);
    chk("i_rs", 32'(rs), 32'd9);
    chk("i_rt", 32'(rt), 32'd8);
    chk("i_im1", 32'(im1), 32'h0000FFFC);
    chk("i_sext", imm_sext, 32'hFFFFFFFC);
    chk("i_zext", imm_zext, 32'h0000FFFC);
    idle(1'b1);
    chk("j_opcode", 32'(opcode), 32'h02);
    chk("j_im2", 32'(im2), 32'h0000010);
    idle(1'b1);
    chk("ij_count", 32'(count), 32'd0);

    // Fill to full, stall a fifth offer, then release it with one pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h10000000 + 32'(i), 32'h00401000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h10000004, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_reject_count", 32'(count), 32'd4);
    step(1'b1, 32'h10000004, 32'h00401010, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 32'h10000004, 32'h00401010, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_refill_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Sustained push+pop at count=2 across pointer wrap
    step(1'b1, 32'h20000000, 32'h00402000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h20000001, 32'h00402004, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 12; i++) begin
      step(1'b1, 32'h20000000 + 32'(i), 32'h00402000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b1);
      chk("sustain_count", 32'(count), 32'd2);
    end
    idle(1'b1);
    idle(1'b1);

    // Flush with count=3 while fetch offers and decode consumes
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h30000000 + 32'(i), 32'h00403000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, 32'h3000000F, 32'h0040303C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_empty("flush");
    idle(1'b0);
    chk("post_flush_count", 32'(count), 32'd0);

    // Reset mid-stream with push+pop active
    step(1'b1, 32'h40000000, 32'h00404000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h40000001, 32'h00404004, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h40000002, 32'h00404008, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_empty("mid_rst");
    step(1'b1, 32'h012A4020, 32'h00400100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_push_valid", 32'(out_valid), 32'd1);
    chk("rst_push_ins", out_ins, 32'h012A4020);
    chk("rst_push_rd", 32'(rd), 32'd8);
    idle(1'b1);
    idle(1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
